// File: rtl/hash_light_feeder.sv
// Byte-stream front end for the 32-bit lightweight hash core: packs bytes into padded
// 4-byte blocks, runs one core request per block, streams the digest back out.
// Optional WAIT watchdog with sticky error state: define HASH_TIMEOUT_EN.
module hash_light_feeder #(
  parameter logic [7:0] PAD_BYTE       = 8'h80,
  parameter int         TIMEOUT_CYCLES = 64,
  parameter int         CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             core_start,
  output logic [7:0]       core_m [0:3],
  input  logic [7:0]       core_d [0:3],
  input  logic             core_done,
  output logic             busy,
  output logic [CNT_W-1:0] blk_count,
  output logic             timeout_err
);

  localparam logic [2:0] COLLECT = 3'd0;
  localparam logic [2:0] START   = 3'd1;
  localparam logic [2:0] WAIT    = 3'd2;
  localparam logic [2:0] EMIT    = 3'd3;
`ifdef HASH_TIMEOUT_EN
  localparam logic [2:0] ERR     = 3'd4;
  localparam int         TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
`endif

  logic [2:0]       r_state;
  logic [1:0]       r_cnt;
  logic [1:0]       r_idx;
  logic             r_last;
  logic [7:0]       r_m   [0:3];
  logic [7:0]       r_dig [0:3];
  logic [CNT_W-1:0] r_blk;
`ifdef HASH_TIMEOUT_EN
  logic [TMO_W-1:0] r_tmo;
  logic             r_tmo_err;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= COLLECT;
      r_cnt   <= 2'd0;
      r_idx   <= 2'd0;
      r_last  <= 1'b0;
      r_blk   <= '0;
      for (int k = 0; k < 4; k++) begin
        r_m[k]   <= 8'h00;
        r_dig[k] <= 8'h00;
      end
`ifdef HASH_TIMEOUT_EN
      r_tmo     <= '0;
      r_tmo_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        COLLECT: begin
          if (in_valid) begin
            r_m[r_cnt] <= in_data;
            if (r_cnt == 2'd3 || in_last) begin
              r_state <= START;
              r_last  <= in_last;
              // Short final block: pad byte right after the data, zeros beyond.
              for (int j = 1; j < 4; j++)
                if (j > int'(r_cnt))
                  r_m[j] <= (j == int'(r_cnt) + 1) ? PAD_BYTE : 8'h00;
            end else begin
              r_cnt <= r_cnt + 2'd1;
            end
          end
        end
        START: begin
          r_state <= WAIT;
`ifdef HASH_TIMEOUT_EN
          r_tmo <= '0;
`endif
        end
        WAIT: begin
          if (core_done) begin
            for (int k = 0; k < 4; k++) r_dig[k] <= core_d[k];
            r_blk   <= r_blk + CNT_W'(1);
            r_idx   <= 2'd0;
            r_state <= EMIT;
          end
`ifdef HASH_TIMEOUT_EN
          else if (r_tmo == TMO_LAST) begin
            r_state   <= ERR;
            r_tmo_err <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
`endif
        end
        EMIT: begin
          if (out_ready) begin
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_cnt   <= 2'd0;
              r_last  <= 1'b0;
              r_state <= COLLECT;
            end
          end
        end
`ifdef HASH_TIMEOUT_EN
        ERR: r_state <= ERR;
`endif
        default: r_state <= COLLECT;
      endcase
    end
  end

  assign in_ready   = (r_state == COLLECT);
  assign core_start = (r_state == START);
  assign out_valid  = (r_state == EMIT);
  assign out_data   = out_valid ? r_dig[r_idx] : 8'h00;
  assign out_last   = out_valid && r_last && (r_idx == 2'd3);
  assign busy       = !((r_state == COLLECT) && (r_cnt == 2'd0));
  assign blk_count  = r_blk;
  assign core_m     = r_m;
`ifdef HASH_TIMEOUT_EN
  assign timeout_err = r_tmo_err;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_hash_light_feeder.sv
// Randomised + directed bench for hash_light_feeder: stub hash core, message-level
// block/digest model, one negedge compare process. Define HASH_TIMEOUT_EN for the watchdog test.
module tb_hash_light_feeder;
  logic       clk = 0, rst_n = 0;
  logic       in_valid = 0, in_last = 0, out_ready = 0, core_done = 0;
  logic [7:0] in_data = 0;
  logic       in_ready, out_valid, out_last, core_start, busy, timeout_err;
  logic [7:0] out_data;
  logic [7:0] core_m [0:3];
  logic [7:0] core_d [0:3];
  logic [15:0] blk_count;

  hash_light_feeder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .core_start(core_start), .core_m(core_m), .core_d(core_d),
    .core_done(core_done), .busy(busy), .blk_count(blk_count), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Message-level model: expected blocks, expected digest bytes {last,data}, block count.
  typedef struct packed { logic [3:0][7:0] b; logic last; } blk_t;
  blk_t        exp_blk[$];
  logic [8:0]  exp_out[$];
  logic [8:0]  obs_out[$];
  logic [31:0] obs_m[$];
  int          model_blk = 0, bytes_in_blk = 0;
  bit          in_flight = 0, cur_last = 0, chk_en = 0, tmo_mode = 0;
  logic [7:0]  cur_m [4];

  // Stub core
  int   lat = 30;
  bit   rand_lat = 0, rand_d = 0, no_done = 0, stale_req = 0;
  int   rdy_mode = 1;
  initial begin
    int timer; bit pend; logic [7:0] d;
    timer = -1; pend = 0;
    for (int k = 0; k < 4; k++) core_d[k] = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        timer = -1; pend = 0; core_done = 0;
      end else begin
        if (pend) begin model_blk++; pend = 0; end
        core_done = 0;
        if (stale_req) begin
          core_done = 1; stale_req = 0;
        end else if (core_start) begin
          timer = rand_lat ? int'($urandom_range(1, 40)) : lat;
        end else if (timer > 0) begin
          timer--;
          if (timer == 0 && !no_done) begin
            for (int k = 0; k < 4; k++) begin
              d = rand_d ? 8'($urandom) : 8'(8'hAA + 8'(k) * 8'h11);
              core_d[k] = d;
              exp_out.push_back({(cur_last && k == 3), d});
            end
            core_done = 1; pend = 1; timer = -1;
          end
        end
      end
    end
  end

  // Sink: 0 random, 1 always ready, 2 pattern 1,0,0,1 while data is offered
  initial begin
    int pi; bit pat [4];
    pi = 0; pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) out_ready = ($urandom % 3) != 0;
      else if (rdy_mode == 1) out_ready = 1;
      else if (out_valid) begin out_ready = pat[pi % 4]; pi++; end
      else out_ready = 1;
    end
  end

  // Single compare process
  initial begin
    bit prev_start, prev_stall, prev_last; logic [7:0] prev_data; int out_cnt; blk_t b;
    prev_start = 0; prev_stall = 0; prev_last = 0; prev_data = 0; out_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_start = 0; prev_stall = 0; out_cnt = 0;
        exp_blk.delete(); exp_out.delete();
        in_flight = 0; bytes_in_blk = 0; model_blk = 0;
      end else if (chk_en) begin
        check("blk_count", blk_count, 32'(model_blk[15:0]));
        check("in_ready", in_ready, !in_flight);
        check("busy", busy, in_flight || bytes_in_blk != 0);
        check("out_valid_idle", out_valid && !in_flight, 0);
        if (!tmo_mode) check("timeout_err", timeout_err, 0);
        if (prev_start && core_start) check("start_pulse_width", 2, 1);
        if (core_start) begin
          if (exp_blk.size() == 0) check("unexpected_start", 1, 0);
          else begin
            b = exp_blk.pop_front();
            for (int k = 0; k < 4; k++) begin
              check($sformatf("core_m[%0d]", k), core_m[k], b.b[k]);
              cur_m[k] = core_m[k];
            end
            cur_last = b.last;
            obs_m.push_back({core_m[0], core_m[1], core_m[2], core_m[3]});
          end
        end
        if (core_done && in_flight && !core_start)
          for (int k = 0; k < 4; k++) check("core_m_stable", core_m[k], cur_m[k]);
        if (prev_stall) begin
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, prev_data);
          check("stall_last", out_last, prev_last);
        end
        if (out_valid && out_ready) begin
          if (exp_out.size() == 0) check("unexpected_out", 1, 0);
          else check("out_byte", {out_last, out_data}, exp_out.pop_front());
          obs_out.push_back({out_last, out_data});
          out_cnt++;
          if (out_cnt == 4) begin out_cnt = 0; in_flight = 0; end
        end
        prev_stall = out_valid && !out_ready;
        prev_data = out_data; prev_last = out_last;
        if (in_valid && in_ready) begin
          bytes_in_blk++;
          if (bytes_in_blk == 4 || in_last) begin bytes_in_blk = 0; in_flight = 1; end
        end
        prev_start = core_start;
      end
    end
  end

  task automatic send_msg(input logic [7:0] msg[$], input bit gaps);
    blk_t b; int n, idx, t; bit hs;
    n = msg.size();
    for (int i = 0; i < n; i += 4) begin
      for (int k = 0; k < 4; k++) begin
        idx = i + k;
        b.b[k] = (idx < n) ? msg[idx] : (idx == n) ? 8'h80 : 8'h00;
      end
      b.last = (i + 4 >= n);
      exp_blk.push_back(b);
    end
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom % 4 == 0)) begin
        in_valid = 0; @(posedge clk); #1;
      end
      in_valid = 1; in_data = msg[i]; in_last = (i == n - 1);
      t = 0;
      do begin
        @(negedge clk); hs = in_ready;
        @(posedge clk); #1; t++;
      end while (!hs && t < 2000);
      if (!hs) begin check("input_accept_timeout", 0, 1); break; end
    end
    in_valid = 0; in_last = 0;
  endtask

  task automatic wait_idle();
    int t; t = 0;
    while ((in_flight || exp_out.size() != 0 || exp_blk.size() != 0) && t < 5000) begin
      @(posedge clk); t++;
    end
    if (t >= 5000) check("idle_wait_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_core_start"}, core_start, 0);
    check({tag, "_core_m"}, {core_m[0], core_m[1], core_m[2], core_m[3]}, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_blk_count"}, blk_count, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0] m[$]; int n; bit seen;
    repeat (3) @(posedge clk); #1;
    check_reset_vals("reset");
    rst_n = 1; chk_en = 1;
    @(posedge clk); #1;

    // 4-byte message
    obs_m.delete(); obs_out.delete();
    m = '{8'h01, 8'h02, 8'h03, 8'h04}; send_msg(m, 0); wait_idle();
    check("t1_starts", obs_m.size(), 1);
    if (obs_m.size() > 0) check("t1_core_m", obs_m[0], 32'h01020304);
    check("t1_nout", obs_out.size(), 4);
    if (obs_out.size() == 4) begin
      check("t1_o0", obs_out[0], 9'h0AA); check("t1_o1", obs_out[1], 9'h0BB);
      check("t1_o2", obs_out[2], 9'h0CC); check("t1_o3", obs_out[3], 9'h1DD);
    end
    check("t1_blk", blk_count, 1);

    // short block padding
    obs_m.delete(); obs_out.delete();
    m = '{8'h11, 8'h22}; send_msg(m, 0); wait_idle();
    if (obs_m.size() > 0) check("t2_core_m", obs_m[0], 32'h11228000);
    if (obs_out.size() == 4) check("t2_o3", obs_out[3], 9'h1DD);
    else check("t2_nout", obs_out.size(), 4);
    check("t2_blk", blk_count, 2);

    // six-byte message, two blocks
    obs_m.delete(); obs_out.delete();
    m = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}; send_msg(m, 0); wait_idle();
    check("t3_starts", obs_m.size(), 2);
    if (obs_m.size() == 2) begin
      check("t3_m0", obs_m[0], 32'h01020304); check("t3_m1", obs_m[1], 32'h05068000);
    end
    if (obs_out.size() == 8) begin
      check("t3_o3", obs_out[3], 9'h0DD); check("t3_o7", obs_out[7], 9'h1DD);
    end else check("t3_nout", obs_out.size(), 8);
    check("t3_blk", blk_count, 4);

    // stalled output 1,0,0,1
    obs_out.delete(); rdy_mode = 2;
    m = '{8'h41, 8'h42, 8'h43, 8'h44}; send_msg(m, 0); wait_idle();
    check("t4_nout", obs_out.size(), 4);
    if (obs_out.size() == 4) begin
      check("t4_o1", obs_out[1], 9'h0BB); check("t4_o3", obs_out[3], 9'h1DD);
    end
    rdy_mode = 1;

    // reset while waiting on the core
    m = '{8'h51, 8'h52, 8'h53, 8'h54}; send_msg(m, 0);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = core_start; end
    check("t5_start_seen", seen, 1);
    repeat (5) @(posedge clk);
    #2 rst_n = 0;
    #1 check_reset_vals("t5_async");
    repeat (2) @(posedge clk); #1 rst_n = 1;
    stale_req = 1;
    repeat (4) @(posedge clk); #1;
    check("t5_stale_blk", blk_count, 0);
    check("t5_stale_valid", out_valid, 0);
    obs_m.delete(); obs_out.delete();
    m = '{8'h0A, 8'h0B, 8'h0C, 8'h0D}; send_msg(m, 0); wait_idle();
    if (obs_m.size() > 0) check("t5_core_m", obs_m[0], 32'h0A0B0C0D);
    else check("t5_starts", obs_m.size(), 1);
    check("t5_blk", blk_count, 1);

    // randomised messages
    rand_lat = 1; rand_d = 1; rdy_mode = 0;
    for (int t = 0; t < 25; t++) begin
      m.delete();
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) m.push_back(8'($urandom));
      send_msg(m, 1);
    end
    wait_idle();
    rand_lat = 0; rand_d = 0; rdy_mode = 1;

`ifdef HASH_TIMEOUT_EN
    // core never answers
    tmo_mode = 1; no_done = 1;
    m = '{8'h61, 8'h62, 8'h63, 8'h64}; send_msg(m, 0);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = core_start; end
    check("t7_start_seen", seen, 1);
    n = 0;
    while (!timeout_err && n < 200) begin @(negedge clk); n++; end
    check("t7_timeout_cycles", n, 65);
    repeat (10) begin
      @(negedge clk);
      check("t7_in_ready", in_ready, 0); check("t7_out_valid", out_valid, 0);
      check("t7_sticky", timeout_err, 1);
    end
    #1 rst_n = 0;
    #1 check_reset_vals("t7_reset");
    repeat (2) @(posedge clk); #1 rst_n = 1;
    tmo_mode = 0; no_done = 0;
    @(posedge clk); #1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
